// File: rtl/burst_acc_defs.sv
// Shared definitions for the burst accumulator: FSM state encodings and a
// constant clog2 helper used to size channel and count fields.
// Pure declarations; no logic, no latency, no flow control.
package burst_acc_defs;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  // Ceiling log2, evaluated at elaboration time; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One channel lane: accumulator, burst counter, sticky overflow and completion detect.
// Latency: acc/cnt/ovf update on the accepting edge; done and sum_nxt are combinational.
// Backpressure: none locally; the top only raises sample_vld when a sample is accepted.
// BURST_ACCUMULATOR_SAT_EN: saturate at 2^ACC_W-1 instead of wrapping.
module accum_lane
  import burst_acc_defs::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int BURST_LEN = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] sample_dat,
  output logic              done,
  output logic [ACC_W-1:0]  sum_nxt,
  output logic              ovf
);

  localparam int CNT_W = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0]   wide;
  logic             carry;

  // Add the zero-extended sample; the extra bit is the carry out of ACC_W.
  always_comb begin
    wide  = {1'b0, acc} + (ACC_W + 1)'(sample_dat);
    carry = wide[ACC_W];
`ifdef BURST_ACCUMULATOR_SAT_EN
    sum_nxt = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum_nxt = wide[ACC_W-1:0];
`endif
    done = sample_vld && (cnt == LAST);
  end

  // Accumulate, count and restart the lane when the burst completes.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (sample_vld) begin
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_nxt;
        cnt <= cnt + 1'b1;
      end
      if (carry) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/burst_accumulator.sv
// Multi-channel burst accumulator: per-channel sums over BURST_LEN samples, one result at a time.
// Latency: Sum_valid rises 1 cycle after the completing sample; results are at least 2 cycles apart.
// Backpressure: In_ready drops while a result waits in EMIT and during Clear; Sum_* hold until Sum_ready.
// BURST_ACCUMULATOR_SAT_EN: lanes saturate instead of wrapping.
module burst_accumulator
  import burst_acc_defs::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int ACC_W     = 16,
  parameter  int NUM_CH    = 4,
  parameter  int BURST_LEN = 16,
  localparam int CH_W      = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic [DATA_W-1:0] In_data,
  input  logic [CH_W-1:0]   In_ch,
  input  logic              In_valid,
  output logic              In_ready,
  output logic [ACC_W-1:0]  Sum_out,
  output logic [CH_W-1:0]   Sum_ch,
  output logic              Sum_valid,
  input  logic              Sum_ready,
  output logic [NUM_CH-1:0] Overflow
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic [NUM_CH-1:0]  lane_vld;
  logic [NUM_CH-1:0]  lane_done;
  logic [ACC_W-1:0]   lane_sum [NUM_CH];
  logic               done_any;
  logic [ACC_W-1:0]   done_sum;

  assign accept = In_valid && In_ready;

  // Out-of-range channels match no lane, so such samples are taken and dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign lane_vld[i] = accept && (In_ch == CH_W'(i));

    accum_lane #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .BURST_LEN (BURST_LEN)
    ) u_lane (
      .Clk        (Clk),
      .Reset      (Reset),
      .clear      (Clear),
      .sample_vld (lane_vld[i]),
      .sample_dat (In_data),
      .done       (lane_done[i]),
      .sum_nxt    (lane_sum[i]),
      .ovf        (Overflow[i])
    );
  end

  // Pick the final sum of the lane the current sample targets.
  always_comb begin
    done_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (In_ch == CH_W'(i)) done_sum = lane_sum[i];
    end
    done_any = |lane_done;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_ACCUM;
    else       state <= state_nxt;
  end

  // Next state: leave ACCUM on a completing sample, return on the result handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (done_any) state_nxt = ST_EMIT;
      ST_EMIT:  if (Sum_valid && Sum_ready) state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

  // Outputs: samples only flow in ACCUM and never while a flush is requested.
  always_comb begin
    In_ready = (state == ST_ACCUM) && !Clear;
  end

  // Result register; Clear leaves a pending result untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Sum_out   <= '0;
      Sum_ch    <= '0;
      Sum_valid <= 1'b0;
    end else if ((state == ST_ACCUM) && done_any) begin
      Sum_out   <= done_sum;
      Sum_ch    <= In_ch;
      Sum_valid <= 1'b1;
    end else if (Sum_valid && Sum_ready) begin
      Sum_valid <= 1'b0;
    end
  end

endmodule

// File: doc/burst_accumulator.md
Name: burst_accumulator

Overview:
- Parametrised, multi-channel successor to the single-register enable-clocked adder.
- Accumulates unsigned samples per channel over a fixed burst length.
- Emits each completed channel sum through a valid/ready output handshake.
- Sits between the sample front-end and the FSM controller; fully synchronous to Clk, with no derived clocks or enable-edged registers.

Parameters:
- DATA_W, 8, input sample width (unsigned).
- ACC_W, 16, accumulator/result width; must satisfy ACC_W >= DATA_W.
- NUM_CH, 4, number of independent channels.
- BURST_LEN, 16, samples per channel per emitted sum; must be >= 1.
- CH_W (localparam), max(1, clog2(NUM_CH)), channel index width.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  reset: synchronous, active-high.
- Clear  input  1  synchronous flush of all accumulators, counters and overflow flags.
- In_data  input  DATA_W  sample.
- In_ch  input  CH_W  target channel of sample.
- In_valid  input  1  sample present.
- In_ready  output  1  block can accept a sample.
- Sum_out  output  ACC_W  completed burst sum.
- Sum_ch  output  CH_W  channel of Sum_out.
- Sum_valid  output  1  Sum_out/Sum_ch valid.
- Sum_ready  input  1  consumer accepts result.
- Overflow  output  NUM_CH  sticky per-channel overflow flag.

Behaviour:
- **Reset** (sync, high): the following clear on the next edge.
  - State=ACCUM; all acc[ch]=0 and cnt[ch]=0.
  - Sum_out=0, Sum_ch=0, Sum_valid=0, Overflow=0.
  - Reset overrides every other input, including mid-burst and in EMIT; a pending result is lost.
- **State ACCUM:** In_ready = ~Clear, combinational.
- **Accept:** a sample is accepted when In_valid & In_ready. Then:
  - acc[In_ch] <= acc[In_ch] + zero-extended In_data, modulo 2^ACC_W.
  - cnt[In_ch] increments.
  - Carry out of ACC_W sets Overflow[In_ch].
- **Burst completion:** when an accepted sample makes cnt reach BURST_LEN:
  - Sum_out <= final sum including that sample; Sum_ch <= In_ch; Sum_valid <= 1.
  - acc[In_ch] <= 0 and cnt[In_ch] <= 0.
  - State -> EMIT.
  - Latency: Sum_valid is high 1 cycle after the completing sample's edge.
- **State EMIT:**
  - In_ready=0; Sum_out, Sum_ch and Sum_valid stay stable.
  - On Sum_valid & Sum_ready: Sum_valid <= 0 and state -> ACCUM. In_ready is high in the following cycle.
  - Minimum spacing between results is 2 cycles.
- **Clear:**
  - Zeroes all acc, cnt and Overflow on the next edge.
  - Clear has priority over a sample in the same cycle; In_ready is low, so no sample is accepted.
  - Clear does not drop a pending EMIT result; Sum_* are untouched.
- **Out-of-range channel:** if In_ch >= NUM_CH (NUM_CH not a power of two), the sample is accepted and discarded; no state changes.
- **Overflow:** stays set until Reset or Clear; it is not cleared by burst completion.
- **Channel independence:** channels accumulate independently and interleave arbitrarily. Only one channel can be in EMIT at a time; other channels stall via In_ready.

Optional Feature:
- Macro: BURST_ACCUMULATOR_SAT_EN.
- Defined: addition saturates at 2^ACC_W-1 instead of wrapping. Overflow still sets on the saturating addition, and a saturated acc stays at max for the rest of the burst.
- Undefined: modulo-2^ACC_W wrap.

Decomposition:
- Shared package/include burst_acc_defs holds:
  - FSM state encodings ST_ACCUM and ST_EMIT.
  - The clog2 helper function.
- One sub-module is natural: accum_lane, instantiated NUM_CH times via generate. It holds one acc, its cnt and its Overflow bit, plus the add/saturate logic and completion detect.
- Top level holds the FSM, the output register and the handshake.

Test Plan:
1. Defaults; ch0 receives In_data = 1..16 consecutively, Sum_ready=1 -> one cycle after 16th sample: Sum_valid=1, Sum_out=136, Sum_ch=0; In_ready back high the cycle after handshake.
2. Interleave ch1 (16 samples of 3) and ch2 (16 samples of 5), alternating -> ch1 completes first, giving Sum_out=48/Sum_ch=1, then 80/2; no cross-talk.
3. Backpressure: hold Sum_ready=0 for 5 cycles after Sum_valid -> Sum_out stable, In_ready=0, the In_valid sample is held off; it is accepted after Sum_ready=1.
4. ACC_W=10, BURST_LEN=8, ch0 receives 8x255 -> Overflow[0] rises after 5th sample.
   - Wrap build: Sum_out=1016.
   - With BURST_ACCUMULATOR_SAT_EN: Sum_out=1023.
5. ch3 receives 5 samples of 10, then Clear, then 16 samples of 1 -> Sum_out=16, Overflow=0; a sample presented during Clear is not accepted.
6. Reset asserted while in EMIT with Sum_valid=1 -> next cycle Sum_valid=0, Sum_out=0, In_ready=1, all counts 0; a subsequent 16x2 burst yields Sum_out=32.
